// File: rtl/grf_hazard_scoreboard_pkg.sv
// Shared widths, encodings and stage-record types for the GRF hazard scoreboard.
// Also holds the per-operand stall and forward-select helpers used by the top.
package grf_hazard_scoreboard_pkg;

    localparam int TUSE_W   = 2;
    localparam int TNEW_W   = 2;
    localparam int MD_CNT_W = 4;

    typedef logic [TUSE_W-1:0] tuse_t;
    typedef logic [TNEW_W-1:0] tnew_t;
    typedef logic [4:0]        reg_t;

    localparam tuse_t TUSE_NONE = 2'd3;

    localparam logic [1:0] FWD_D_GRF  = 2'd0;
    localparam logic [1:0] FWD_D_E    = 2'd1;
    localparam logic [1:0] FWD_D_M    = 2'd2;
    localparam logic [1:0] FWD_E_PIPE = 2'd0;
    localparam logic [1:0] FWD_E_M    = 2'd1;
    localparam logic [1:0] FWD_E_W    = 2'd2;

    typedef struct packed {
        logic  valid;
        reg_t  wa;
        tnew_t tnew;
    } dst_rec_t;

    typedef struct packed {
        dst_rec_t dst;
        reg_t     rs;
        reg_t     rt;
    } e_rec_t;

    // Live match: a valid record writing a non-zero register equal to x.
    function automatic logic rec_hit(dst_rec_t r, reg_t x);
        return r.valid && (r.wa != 5'd0) && (r.wa == x);
    endfunction

    function automatic tnew_t tnew_dec(tnew_t t);
        return (t == '0) ? '0 : t - tnew_t'(1);
    endfunction

    function automatic logic opnd_stall(reg_t x, tuse_t tuse, dst_rec_t e, dst_rec_t m);
        if (tuse == TUSE_NONE || x == 5'd0) return 1'b0;
        if (rec_hit(e, x)) return e.tnew > tuse;
        if (rec_hit(m, x)) return m.tnew > tuse;
        return 1'b0;
    endfunction

    // The younger record decides; a not-yet-ready younger producer masks older ones.
    function automatic logic [1:0] fwd_d_sel(reg_t x, dst_rec_t e, dst_rec_t m);
        if (rec_hit(e, x)) return (e.tnew == '0) ? FWD_D_E : FWD_D_GRF;
        if (rec_hit(m, x)) return (m.tnew == '0) ? FWD_D_M : FWD_D_GRF;
        return FWD_D_GRF;
    endfunction

    function automatic logic [1:0] fwd_e_sel(reg_t x, dst_rec_t m, dst_rec_t w);
        if (x == 5'd0) return FWD_E_PIPE;
        if (rec_hit(m, x) && m.tnew == '0) return FWD_E_M;
        if (rec_hit(w, x) && w.tnew == '0) return FWD_E_W;
        return FWD_E_PIPE;
    endfunction

endpackage

// File: rtl/grf_hazard_scoreboard_md_busy_counter.sv
// Busy window for the multi-cycle mult/div unit; a new start restarts the count.
module grf_hazard_scoreboard_md_busy_counter
    import grf_hazard_scoreboard_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    logic [MD_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= is_div ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - MD_CNT_W'(1);
        end
    end

    assign busy = !reset && (start || (cnt_q != '0));

endmodule

// File: rtl/grf_hazard_scoreboard.sv
// Hazard controller for the D/E/M/W pipeline: tracks in-flight writers, raises stall
// and selects operand forwarding for D and E. W->D is left to the GRF write-through.
module grf_hazard_scoreboard
    import grf_hazard_scoreboard_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_wa,
    input  logic       d_regwrite,
    input  logic [1:0] d_tnew,
    input  logic       d_md_use,
    input  logic       e_md_start,
    input  logic       e_md_is_div,
    output logic       stall,
    output logic [1:0] fwd_d_rs_sel,
    output logic [1:0] fwd_d_rt_sel,
    output logic [1:0] fwd_e_rs_sel,
    output logic [1:0] fwd_e_rt_sel,
    output logic       md_busy
);

    e_rec_t   e_q;
    dst_rec_t m_q;
    dst_rec_t w_q;
    logic     rs_stall;
    logic     rt_stall;
    logic     md_stall;
    logic     stall_int;

    grf_hazard_scoreboard_md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_counter (
        .clk    (clk),
        .reset  (reset),
        .start  (e_md_start),
        .is_div (e_md_is_div),
        .busy   (md_busy)
    );

    always_comb begin
        rs_stall  = opnd_stall(d_rs, d_tuse_rs, e_q.dst, m_q);
        rt_stall  = opnd_stall(d_rt, d_tuse_rt, e_q.dst, m_q);
        md_stall  = d_md_use && md_busy;
        stall_int = rs_stall || rt_stall || md_stall;
    end

    assign stall        = !reset && stall_int;
    assign fwd_d_rs_sel = reset ? FWD_D_GRF  : fwd_d_sel(d_rs, e_q.dst, m_q);
    assign fwd_d_rt_sel = reset ? FWD_D_GRF  : fwd_d_sel(d_rt, e_q.dst, m_q);
    assign fwd_e_rs_sel = reset ? FWD_E_PIPE : fwd_e_sel(e_q.rs, m_q, w_q);
    assign fwd_e_rt_sel = reset ? FWD_E_PIPE : fwd_e_sel(e_q.rt, m_q, w_q);

    // E/M/W keep draining under stall; only the D->E hand-off turns into a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            w_q <= m_q;
            m_q <= '{valid: e_q.dst.valid, wa: e_q.dst.wa, tnew: tnew_dec(e_q.dst.tnew)};
            if (stall_int) begin
                e_q <= '0;
            end else begin
                e_q <= '{dst: '{valid: d_regwrite, wa: d_wa, tnew: d_tnew},
                         rs: d_rs, rt: d_rt};
            end
        end
    end

endmodule

// File: tb/tb_grf_hazard_scoreboard.sv
// Scenario bench for grf_hazard_scoreboard: expected outputs are queued when each
// D-stage issue is driven and compared against the DUT at the following negedge.
module tb_grf_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_wa;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_regwrite, d_md_use, e_md_start, e_md_is_div;
    logic       stall, md_busy;
    logic [1:0] fwd_d_rs_sel, fwd_d_rt_sel, fwd_e_rs_sel, fwd_e_rt_sel;
    logic [9:0] obs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    grf_hazard_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .d_rs         (d_rs),
        .d_rt         (d_rt),
        .d_tuse_rs    (d_tuse_rs),
        .d_tuse_rt    (d_tuse_rt),
        .d_wa         (d_wa),
        .d_regwrite   (d_regwrite),
        .d_tnew       (d_tnew),
        .d_md_use     (d_md_use),
        .e_md_start   (e_md_start),
        .e_md_is_div  (e_md_is_div),
        .stall        (stall),
        .fwd_d_rs_sel (fwd_d_rs_sel),
        .fwd_d_rt_sel (fwd_d_rt_sel),
        .fwd_e_rs_sel (fwd_e_rs_sel),
        .fwd_e_rt_sel (fwd_e_rt_sel),
        .md_busy      (md_busy)
    );

    assign obs = {stall, fwd_d_rs_sel, fwd_d_rt_sel, fwd_e_rs_sel, fwd_e_rt_sel, md_busy};

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tur;
        logic [1:0] tut;
        logic [4:0] wa;
        logic       rw;
        logic [1:0] tn;
        logic       mdu;
        logic       mds;
        logic       mdd;
    } stim_t;

    // v = {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy}
    typedef struct packed {
        logic       chk;
        logic [9:0] v;
    } exp_t;

    exp_t expq[$];

    function automatic stim_t ins(int rs, int rt, int tur, int tut, int wa, int rw, int tn);
        stim_t s = '0;
        s.rs  = 5'(rs);
        s.rt  = 5'(rt);
        s.tur = 2'(tur);
        s.tut = 2'(tut);
        s.wa  = 5'(wa);
        s.rw  = 1'(rw);
        s.tn  = 2'(tn);
        return s;
    endfunction

    function automatic stim_t nop();
        return ins(0, 0, 3, 3, 0, 0, 0);
    endfunction

    function automatic stim_t md(stim_t s, int use_md, int start, int is_div);
        stim_t r = s;
        r.mdu = 1'(use_md);
        r.mds = 1'(start);
        r.mdd = 1'(is_div);
        return r;
    endfunction

    function automatic stim_t with_rst(stim_t s);
        stim_t r = s;
        r.rst = 1'b1;
        return r;
    endfunction

    function automatic exp_t ex(int st, int dr, int dt, int er, int et, int bz);
        exp_t e;
        e.chk = 1'b1;
        e.v   = {1'(st), 2'(dr), 2'(dt), 2'(er), 2'(et), 1'(bz)};
        return e;
    endfunction

    function automatic exp_t nochk();
        exp_t e = '0;
        return e;
    endfunction

    task automatic drive(input stim_t s, input exp_t e);
        reset       = s.rst;
        d_rs        = s.rs;
        d_rt        = s.rt;
        d_tuse_rs   = s.tur;
        d_tuse_rt   = s.tut;
        d_wa        = s.wa;
        d_regwrite  = s.rw;
        d_tnew      = s.tn;
        d_md_use    = s.mdu;
        e_md_start  = s.mds;
        e_md_is_div = s.mdd;
        expq.push_back(e);
    endtask

    task automatic test_reset();
        stim_t st[$];
        exp_t  xq[$];
        exp_t  e;
        st.push_back(with_rst(nop()));             xq.push_back(nochk());
        st.push_back(with_rst(md(nop(), 0, 1, 1))); xq.push_back(nochk());
        for (int i = 0; i < 3; i++) begin
            st.push_back(nop());                    xq.push_back(ex(0, 0, 0, 0, 0, 0));
        end
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i], xq[i]);
            @(negedge clk);
            e = expq.pop_front();
            if (e.chk) begin
                checks++;
                if (obs !== e.v) begin
                    errors++;
                    $display("FAIL reset cyc %0d got %b want %b", i, obs, e.v);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_use();
        stim_t st[$];
        exp_t  xq[$];
        exp_t  e;
        st.push_back(ins(29, 0, 1, 3, 8, 1, 2)); xq.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back(ins(8, 0, 0, 0, 0, 0, 0));  xq.push_back(ex(1, 0, 0, 0, 0, 0));
        st.push_back(ins(8, 0, 0, 0, 0, 0, 0));  xq.push_back(ex(1, 0, 0, 0, 0, 0));
        st.push_back(ins(8, 0, 0, 0, 0, 0, 0));  xq.push_back(ex(0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            st.push_back(nop());                  xq.push_back(ex(0, 0, 0, 0, 0, 0));
        end
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i], xq[i]);
            @(negedge clk);
            e = expq.pop_front();
            if (e.chk) begin
                checks++;
                if (obs !== e.v) begin
                    errors++;
                    $display("FAIL load_use cyc %0d got %b want %b", i, obs, e.v);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_alu_use();
        stim_t st[$];
        exp_t  xq[$];
        exp_t  e;
        st.push_back(ins(1, 2, 1, 1, 9, 1, 1));  xq.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back(ins(9, 3, 1, 1, 10, 1, 1)); xq.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back(ins(9, 4, 1, 1, 11, 1, 1)); xq.push_back(ex(0, 2, 0, 1, 0, 0));
        st.push_back(nop());                     xq.push_back(ex(0, 0, 0, 2, 0, 0));
        for (int i = 0; i < 3; i++) begin
            st.push_back(nop());                 xq.push_back(ex(0, 0, 0, 0, 0, 0));
        end
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i], xq[i]);
            @(negedge clk);
            e = expq.pop_front();
            if (e.chk) begin
                checks++;
                if (obs !== e.v) begin
                    errors++;
                    $display("FAIL alu_use cyc %0d got %b want %b", i, obs, e.v);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_link();
        stim_t st[$];
        exp_t  xq[$];
        exp_t  e;
        // jal immediately followed by jr, then again with a nop in between
        st.push_back(ins(0, 0, 3, 3, 31, 1, 0)); xq.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back(ins(31, 0, 0, 3, 0, 0, 0)); xq.push_back(ex(0, 1, 0, 0, 0, 0));
        st.push_back(nop());                     xq.push_back(ex(0, 0, 0, 1, 0, 0));
        st.push_back(nop());                     xq.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back(ins(0, 0, 3, 3, 31, 1, 0)); xq.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back(nop());                     xq.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back(ins(31, 0, 0, 3, 0, 0, 0)); xq.push_back(ex(0, 2, 0, 0, 0, 0));
        st.push_back(nop());                     xq.push_back(ex(0, 0, 0, 2, 0, 0));
        for (int i = 0; i < 3; i++) begin
            st.push_back(nop());                 xq.push_back(ex(0, 0, 0, 0, 0, 0));
        end
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i], xq[i]);
            @(negedge clk);
            e = expq.pop_front();
            if (e.chk) begin
                checks++;
                if (obs !== e.v) begin
                    errors++;
                    $display("FAIL link cyc %0d got %b want %b", i, obs, e.v);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_zero_and_dual();
        stim_t st[$];
        exp_t  xq[$];
        exp_t  e;
        st.push_back(ins(29, 0, 1, 3, 0, 1, 2)); xq.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back(ins(0, 0, 0, 0, 0, 0, 0));  xq.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back(nop());                     xq.push_back(ex(0, 0, 0, 0, 0, 0));
        // rs hits M (load), rt hits E (alu); then rt forwarded from M, rs from GRF
        st.push_back(ins(29, 0, 1, 3, 5, 1, 2)); xq.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back(ins(1, 2, 1, 1, 6, 1, 1));  xq.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back(ins(5, 6, 0, 0, 0, 0, 0));  xq.push_back(ex(1, 0, 0, 0, 0, 0));
        st.push_back(ins(5, 6, 0, 0, 0, 0, 0));  xq.push_back(ex(0, 0, 2, 0, 0, 0));
        st.push_back(nop());                     xq.push_back(ex(0, 0, 0, 0, 2, 0));
        // younger not-ready writer of $7 masks the ready older one
        st.push_back(ins(1, 2, 1, 1, 7, 1, 1));  xq.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back(ins(29, 0, 1, 3, 7, 1, 2)); xq.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back(ins(7, 0, 2, 3, 0, 0, 0));  xq.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back(nop());                     xq.push_back(ex(0, 0, 0, 2, 0, 0));
        for (int i = 0; i < 3; i++) begin
            st.push_back(nop());                 xq.push_back(ex(0, 0, 0, 0, 0, 0));
        end
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i], xq[i]);
            @(negedge clk);
            e = expq.pop_front();
            if (e.chk) begin
                checks++;
                if (obs !== e.v) begin
                    errors++;
                    $display("FAIL zero_dual cyc %0d got %b want %b", i, obs, e.v);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_mult_div();
        stim_t st[$];
        exp_t  xq[$];
        exp_t  e;
        st.push_back(md(nop(), 0, 1, 1));        xq.push_back(ex(0, 0, 0, 0, 0, 1));
        for (int i = 0; i < 10; i++) begin
            st.push_back(md(nop(), 1, 0, 0));    xq.push_back(ex(1, 0, 0, 0, 0, 1));
        end
        st.push_back(md(nop(), 1, 0, 0));        xq.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back(md(nop(), 0, 1, 0));        xq.push_back(ex(0, 0, 0, 0, 0, 1));
        for (int i = 0; i < 5; i++) begin
            st.push_back(nop());                 xq.push_back(ex(0, 0, 0, 0, 0, 1));
        end
        st.push_back(nop());                     xq.push_back(ex(0, 0, 0, 0, 0, 0));
        // mult issued two cycles into a div restarts the window at MULT_CYCLES
        st.push_back(md(nop(), 0, 1, 1));        xq.push_back(ex(0, 0, 0, 0, 0, 1));
        st.push_back(nop());                     xq.push_back(ex(0, 0, 0, 0, 0, 1));
        st.push_back(nop());                     xq.push_back(ex(0, 0, 0, 0, 0, 1));
        st.push_back(md(nop(), 0, 1, 0));        xq.push_back(ex(0, 0, 0, 0, 0, 1));
        for (int i = 0; i < 5; i++) begin
            st.push_back(nop());                 xq.push_back(ex(0, 0, 0, 0, 0, 1));
        end
        st.push_back(nop());                     xq.push_back(ex(0, 0, 0, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i], xq[i]);
            @(negedge clk);
            e = expq.pop_front();
            if (e.chk) begin
                checks++;
                if (obs !== e.v) begin
                    errors++;
                    $display("FAIL mult_div cyc %0d got %b want %b", i, obs, e.v);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        stim_t st[$];
        exp_t  xq[$];
        exp_t  e;
        st.push_back(md(nop(), 0, 1, 1));        xq.push_back(ex(0, 0, 0, 0, 0, 1));
        for (int i = 0; i < 3; i++) begin
            st.push_back(nop());                 xq.push_back(ex(0, 0, 0, 0, 0, 1));
        end
        st.push_back(ins(29, 0, 1, 3, 8, 1, 2)); xq.push_back(ex(0, 0, 0, 0, 0, 1));
        // cnt is 6 and lw $8 sits in E when reset (and a competing start) arrives
        st.push_back(with_rst(md(ins(8, 0, 0, 3, 0, 0, 0), 1, 1, 1))); xq.push_back(nochk());
        st.push_back(md(ins(8, 0, 0, 3, 0, 0, 0), 1, 0, 0)); xq.push_back(ex(0, 0, 0, 0, 0, 0));
        st.push_back(nop());                     xq.push_back(ex(0, 0, 0, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i], xq[i]);
            @(negedge clk);
            e = expq.pop_front();
            if (e.chk) begin
                checks++;
                if (obs !== e.v) begin
                    errors++;
                    $display("FAIL reset_mid cyc %0d got %b want %b", i, obs, e.v);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_alu_use();
        test_link();
        test_zero_and_dual();
        test_mult_div();
        test_reset_mid();
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL queue_drained left %0d want 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
